// File: rtl/game_sprite_pkg.sv
// Shared types and screen constants for the sprite motion controller.
package game_sprite_pkg;

  localparam int SCREEN_WIDTH  = 640;
  localparam int SCREEN_HEIGHT = 480;
  localparam int VEL_WIDTH     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } sprite_state_e;

  typedef logic signed [VEL_WIDTH-1:0] sprite_vel_t;

endpackage

// File: rtl/game_axis_step.sv
// Single-axis next-position calculation with edge handling.
// GAME_SPRITE_MOVER_BOUNCE_EN selects reflection; otherwise the axis stops at the edge.
module game_axis_step #(
  parameter int W   = 10,
  parameter int MAX = 624,
  parameter int DW  = 4
) (
  input  logic [W-1:0]  pos,
  input  logic [DW-1:0] vel,
  output logic [W-1:0]  next_pos,
  output logic [DW-1:0] next_vel,
  output logic          hit
);

  localparam logic signed [W+1:0] MAX_S = (W+2)'(MAX);

  logic signed [W+1:0] sum;

`ifdef GAME_SPRITE_MOVER_BOUNCE_EN
  localparam logic [DW-1:0] VEL_MIN = {1'b1, {(DW-1){1'b0}}};
  localparam logic [DW-1:0] VEL_MAX = {1'b0, {(DW-1){1'b1}}};

  logic [DW-1:0] edge_vel;

  // The most negative velocity has no positive twin, so it saturates.
  always_comb begin
    edge_vel = (vel == VEL_MIN) ? VEL_MAX : (~vel + DW'(1));
  end
`else
  logic [DW-1:0] edge_vel;

  always_comb begin
    edge_vel = '0;
  end
`endif

  always_comb begin
    sum      = $signed({2'b00, pos}) + $signed({{(W+2-DW){vel[DW-1]}}, vel});
    next_pos = pos;
    next_vel = vel;
    hit      = 1'b0;
    if (sum < 0) begin
      next_pos = '0;
      next_vel = edge_vel;
      hit      = 1'b1;
    end else if (sum > MAX_S) begin
      next_pos = MAX_S[W-1:0];
      next_vel = edge_vel;
      hit      = 1'b1;
    end else begin
      next_pos = sum[W-1:0];
      hit      = (|vel) && ((sum == '0) || (sum == MAX_S));
    end
  end

endmodule

// File: rtl/game_sprite_mover.sv
// Sprite motion controller: owns position/velocity and steps every FRAME_DIV frame ticks.
// Edge behaviour is selected by GAME_SPRITE_MOVER_BOUNCE_EN (see game_axis_step).
module game_sprite_mover
  import game_sprite_pkg::*;
#(
  parameter int SPRITE_WIDTH  = 16,
  parameter int SPRITE_HEIGHT = 16,
  parameter int screen_width  = SCREEN_WIDTH,
  parameter int screen_height = SCREEN_HEIGHT,
  parameter int w_x           = $clog2(screen_width),
  parameter int w_y           = $clog2(screen_height),
  parameter int DXY_WIDTH     = 4,
  parameter int FRAME_DIV     = 1,
  parameter int INIT_X        = 0,
  parameter int INIT_Y        = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 frame_tick,
  input  logic                 sprite_write_xy,
  input  logic                 sprite_write_dxy,
  input  logic [w_x-1:0]       sprite_write_x,
  input  logic [w_y-1:0]       sprite_write_y,
  input  logic [DXY_WIDTH-1:0] sprite_write_dx,
  input  logic [DXY_WIDTH-1:0] sprite_write_dy,
  input  logic                 sprite_enable_update,
  output logic [w_x-1:0]       sprite_x,
  output logic [w_y-1:0]       sprite_y,
  output logic [DXY_WIDTH-1:0] sprite_dx,
  output logic [DXY_WIDTH-1:0] sprite_dy,
  output logic                 moving,
  output logic                 edge_hit
);

  localparam int MAX_X = screen_width - SPRITE_WIDTH;
  localparam int MAX_Y = screen_height - SPRITE_HEIGHT;
  localparam logic [w_x-1:0] MAX_X_V = w_x'(MAX_X);
  localparam logic [w_y-1:0] MAX_Y_V = w_y'(MAX_Y);
  localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);

  sprite_state_e        state_q, state_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [w_x-1:0]       x_q, x_d;
  logic [w_y-1:0]       y_q, y_d;
  logic [DXY_WIDTH-1:0] dx_q, dx_d;
  logic [DXY_WIDTH-1:0] dy_q, dy_d;
  logic                 moving_q, moving_d;
  logic                 edge_hit_q, edge_hit_d;

  logic [w_x-1:0]       step_x;
  logic [w_y-1:0]       step_y;
  logic [DXY_WIDTH-1:0] step_dx, step_dy;
  logic                 hit_x, hit_y;
  logic                 commit;

  game_axis_step #(.W(w_x), .MAX(MAX_X), .DW(DXY_WIDTH)) u_axis_x (
    .pos      (x_q),
    .vel      (dx_q),
    .next_pos (step_x),
    .next_vel (step_dx),
    .hit      (hit_x)
  );

  game_axis_step #(.W(w_y), .MAX(MAX_Y), .DW(DXY_WIDTH)) u_axis_y (
    .pos      (y_q),
    .vel      (dy_q),
    .next_pos (step_y),
    .next_vel (step_dy),
    .hit      (hit_y)
  );

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    case (state_q)
      IDLE: begin
        div_d = '0;
        if (sprite_enable_update) state_d = RUN;
      end
      RUN: begin
        if (!sprite_enable_update) begin
          state_d = IDLE;
          div_d   = '0;
        end else if (frame_tick) begin
          if (div_q == DIV_LAST) begin
            div_d   = '0;
            state_d = STEP;
          end else begin
            div_d = div_q + DIV_W'(1);
          end
        end
      end
      STEP: begin
        state_d = sprite_enable_update ? RUN : IDLE;
      end
      default: begin
        state_d = IDLE;
        div_d   = '0;
      end
    endcase
    moving_d = (state_d != IDLE);
  end

  // A write in the commit cycle overrides the step result for that quantity only.
  always_comb begin
    commit     = (state_q == STEP);
    x_d        = x_q;
    y_d        = y_q;
    dx_d       = dx_q;
    dy_d       = dy_q;
    edge_hit_d = commit && (hit_x || hit_y);
    if (commit) begin
      x_d  = step_x;
      y_d  = step_y;
      dx_d = step_dx;
      dy_d = step_dy;
    end
    if (sprite_write_xy) begin
      x_d = (sprite_write_x > MAX_X_V) ? MAX_X_V : sprite_write_x;
      y_d = (sprite_write_y > MAX_Y_V) ? MAX_Y_V : sprite_write_y;
    end
    if (sprite_write_dxy) begin
      dx_d = sprite_write_dx;
      dy_d = sprite_write_dy;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      div_q      <= '0;
      x_q        <= w_x'(INIT_X);
      y_q        <= w_y'(INIT_Y);
      dx_q       <= '0;
      dy_q       <= '0;
      moving_q   <= 1'b0;
      edge_hit_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      x_q        <= x_d;
      y_q        <= y_d;
      dx_q       <= dx_d;
      dy_q       <= dy_d;
      moving_q   <= moving_d;
      edge_hit_q <= edge_hit_d;
    end
  end

  assign sprite_x  = x_q;
  assign sprite_y  = y_q;
  assign sprite_dx = dx_q;
  assign sprite_dy = dy_q;
  assign moving    = moving_q;
  assign edge_hit  = edge_hit_q;

endmodule

// File: doc/game_sprite_mover.md
Name: game_sprite_mover

Overview:
- Per-sprite motion controller sitting directly upstream of the game sprite display stage.
- Owns the sprite's registered position (sprite_x/sprite_y) and velocity (sprite_dx/sprite_dy).
- Advances position once every FRAME_DIV frame ticks and reflects velocity at screen edges.
- Outputs feed the display stage's sprite_x/sprite_y inputs directly.

Parameters:
- SPRITE_WIDTH, 16, sprite width in pixels.
- SPRITE_HEIGHT, 16, sprite height in pixels.
- screen_width, 640, visible width.
- screen_height, 480, visible height.
- w_x, $clog2(screen_width), x coordinate width.
- w_y, $clog2(screen_height), y coordinate width.
- DXY_WIDTH, 4, signed two's-complement velocity width.
- FRAME_DIV, 1, frame ticks per position step (>=1).
- INIT_X, 0, reset x.
- INIT_Y, 0, reset y.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- frame_tick  in  1  one-cycle pulse per frame (end of active video).
- sprite_write_xy  in  1  load position strobe.
- sprite_write_dxy  in  1  load velocity strobe.
- sprite_write_x  in  w_x  position x to load.
- sprite_write_y  in  w_y  position y to load.
- sprite_write_dx  in  DXY_WIDTH  signed velocity x to load.
- sprite_write_dy  in  DXY_WIDTH  signed velocity y to load.
- sprite_enable_update  in  1  level: motion enabled.
- sprite_x  out  w_x  current x (to display stage).
- sprite_y  out  w_y  current y.
- sprite_dx  out  DXY_WIDTH  current velocity x.
- sprite_dy  out  DXY_WIDTH  current velocity y.
- moving  out  1  high in RUN or STEP.
- edge_hit  out  1  one-cycle pulse when a step touched or crossed an edge.

Interface (already decided): one clock clk; reset rst_n is asynchronous and active-low.

Behaviour:
- Reset values: sprite_x=INIT_X, sprite_y=INIT_Y, dx=dy=0, moving=0, edge_hit=0, state=IDLE, divider=0.
- All outputs are registered.
- FSM IDLE:
  - sprite_enable_update=1 -> RUN.
  - Divider held at 0.
- FSM RUN:
  - sprite_enable_update=0 -> IDLE; divider cleared.
  - On frame_tick: if divider==FRAME_DIV-1, divider<=0 and -> STEP; else divider++.
- FSM STEP (one cycle):
  - Commits the new x/y/dx/dy and drives edge_hit for that step.
  - -> RUN, or -> IDLE if sprite_enable_update=0 (the step still commits).
  - frame_tick in STEP is ignored; the divider does not count.
- Latency: tick sampled at edge k -> STEP after edge k -> new position visible after edge k+1.
- Step arithmetic:
  - nx = {2'b0,x} + sign-extended dx, computed in w_x+2 signed bits; same for y in w_y+2.
  - max_x = screen_width-SPRITE_WIDTH; max_y = screen_height-SPRITE_HEIGHT.
  - nx<0 -> x=0, dx=-dx. nx>max_x -> x=max_x, dx=-dx. Otherwise x=nx. Same rule for y.
  - edge_hit=1 if either axis reflected, or landed exactly on 0 or max with nonzero velocity.
  - Negation of the most-negative velocity (-8 at width 4) saturates to +7.
- Writes, accepted in any state:
  - sprite_write_xy loads position next edge; values above max are clamped to max.
  - sprite_write_dxy loads velocity next edge.
  - Write coincident with a STEP commit: write wins for the written quantity; the step's result for that quantity is discarded. Unwritten quantities still take the step result.
  - Simultaneous xy and dxy writes are both applied.
- dx=dy=0 in RUN: steps still occur, position is unchanged, no edge_hit.
- Reset mid-STEP: returns immediately to reset values; no partial commit.

Optional Feature:
- Macro: GAME_SPRITE_MOVER_BOUNCE_EN.
- Defined: edge reflection as described above.
- Undefined:
  - Crossing an edge clamps position to the edge and zeroes that axis' velocity; edge_hit still pulses.
  - Sprite stops on that axis until the next sprite_write_dxy.

Decomposition:
- Shared package game_sprite_pkg:
  - State enum typedef (IDLE, RUN, STEP).
  - Signed velocity typedef.
  - Screen size localparams.
- One natural sub-module: game_axis_step.
  - Pure combinational single-axis next-position/reflect/saturate, parameterised by coordinate width and max.
  - Instantiated twice (x, y).

Test Plan:
- Reset: rst_n low mid-run -> x=INIT_X, y=INIT_Y, dx=dy=0, moving=0 asynchronously.
- Linear step: write x=100, y=50, dx=+3, dy=-2, enable, FRAME_DIV=1, one tick -> after 2 edges x=103, y=48, edge_hit=0.
- Right-edge bounce: x=622, dx=+5, tick -> x=624, dx=-5, edge_hit=1 pulse.
  - With macro undefined -> x=624, dx=0.
- Top reflect and saturate: y=1, dy=-8, tick -> y=0, dy=+7, edge_hit=1.
- Divider and disable: FRAME_DIV=3, 3 ticks -> exactly one step. Drop enable after tick 2 -> no step; divider cleared on re-enable.
- Write/step collision: sprite_write_xy x=200 in the STEP cycle -> x=200 (write wins), y takes the step result.
